// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and decode handoff.
// master = fetch stage, slave = memory/execute/decode environment.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] instr_pc;
    logic        misalign;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, instr_pc, misalign,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, instr_pc, misalign,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request feeding a 2-entry {pc, instr} buffer.
// Define FETCH_MISALIGN_TRAP_EN to trap (halt) on misaligned redirect targets.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} stateT;

    stateT       state, stateNext;
    logic        imemReq;
    logic [31:0] fetchPc;
    logic [31:0] reqPc;
    logic        kill;
    logic [1:0]  count, occNext;
    logic [31:0] headPc, headInstr, tailPc, tailInstr;
    logic        pop, granted, arrive, push, trap;
    logic [31:0] targetPc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalignQ;
    assign trap     = bus.redirect && (bus.redirect_pc[1:0] != 2'b00) && (state != HALT);
    assign targetPc = bus.redirect_pc;
    assign bus.misalign = misalignQ;
`else
    logic unusedPcBits;
    assign unusedPcBits = ^bus.redirect_pc[1:0];
    assign trap         = 1'b0;
    assign targetPc     = {bus.redirect_pc[31:2], 2'b00};
    assign bus.misalign = 1'b0;
`endif

    assign bus.imem_req    = imemReq;
    assign bus.imem_addr   = fetchPc;
    assign bus.instr_valid = (count != 2'd0);
    assign bus.instr       = headInstr;
    assign bus.op          = headInstr[6:0];
    assign bus.instr_pc    = headPc;

    always_comb begin
        pop     = (count != 2'd0) && bus.instr_ready;
        granted = imemReq && bus.imem_gnt;
        arrive  = (state == WAIT) && bus.imem_rvalid;
        push    = arrive && !kill && !bus.redirect;
        if (bus.redirect) occNext = '0;
        else              occNext = count + {1'b0, push} - {1'b0, pop};

        // Occupancy after this cycle gates the next request, so at most one is ever in flight.
        stateNext = state;
        unique case (state)
            IDLE:    if (occNext < 2'd2) stateNext = REQ;
            REQ:     if (granted) stateNext = WAIT;
            WAIT:    if (arrive) stateNext = (occNext < 2'd2) ? REQ : IDLE;
            HALT:    stateNext = HALT;
            default: stateNext = IDLE;
        endcase
        if (trap) stateNext = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            imemReq   <= 1'b0;
            fetchPc   <= RESET_PC;
            reqPc     <= '0;
            kill      <= 1'b0;
            count     <= '0;
            headPc    <= '0;
            headInstr <= '0;
            tailPc    <= '0;
            tailInstr <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalignQ <= 1'b0;
`endif
        end else begin
            state   <= stateNext;
            imemReq <= (stateNext == REQ);
            count   <= occNext;

            if (bus.redirect && state != HALT) fetchPc <= targetPc;
            else if (granted)                  fetchPc <= fetchPc + 32'd4;
            if (granted) reqPc <= fetchPc;

            // A response still owed to the old stream must be swallowed when it arrives.
            if (trap)
                kill <= 1'b0;
            else if (bus.redirect && state != HALT)
                kill <= granted || ((state == WAIT) && !arrive);
            else if (arrive)
                kill <= 1'b0;

            if (!bus.redirect) begin
                if (pop && push) begin
                    if (count == 2'd1) begin
                        headPc    <= reqPc;
                        headInstr <= bus.imem_rdata;
                    end else begin
                        headPc    <= tailPc;
                        headInstr <= tailInstr;
                        tailPc    <= reqPc;
                        tailInstr <= bus.imem_rdata;
                    end
                end else if (pop) begin
                    headPc    <= tailPc;
                    headInstr <= tailInstr;
                end else if (push) begin
                    if (count == 2'd0) begin
                        headPc    <= reqPc;
                        headInstr <= bus.imem_rdata;
                    end else begin
                        tailPc    <= reqPc;
                        tailInstr <= bus.imem_rdata;
                    end
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (trap) misalignQ <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory responder plus a queue-based model of the
// expected instruction stream (program order from reset/redirect targets).
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] pc; logic [31:0] ins;} entryT;

    int unsigned checks = 0;
    int unsigned errors = 0;

    entryT       q[$];
    logic [31:0] nextFetch = RST_PC;
    int unsigned epoch = 0;
    bit          pendValid = 0;
    logic [31:0] pendAddr = '0;
    int unsigned pendCnt = 0;
    int unsigned pendEpoch = 0;
    bit          halted = 0;
    bit          justReset = 0;
    bit          prevHold = 0;
    logic [31:0] prevAddr = '0;
    bit          lastGrant = 0;
    int unsigned sinceProgress = 0;

    int unsigned gntPct = 100, readyPct = 100, redirPct = 0;
    int unsigned delayMin = 0, delayMax = 0;
    bit          forceRedir = 0, forceStale = 0;
    logic [31:0] forceRedirPc = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [6:0] opc;
        case (a[3:2])
            2'd0:    opc = 7'b0000011;
            2'd1:    opc = 7'b0010011;
            2'd2:    opc = 7'b0110011;
            default: opc = 7'b1100011;
        endcase
        return {a[26:2] ^ 25'h0A5_A5A5, opc};
    endfunction

    function automatic logic [31:0] randTarget();
        logic [31:0] t;
        t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    // One clock: check outputs at the falling edge, drive inputs, advance the model to the next rising edge.
    task automatic step(input bit doRst);
        bit          granted, pop, rv, respOk;
        logic [31:0] rd, tgt;
        int unsigned oldEpoch;
        @(negedge clk);
        if (!rst) begin
            checkVal("valid", 32'(bus.instr_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                checkVal("instrPc", bus.instr_pc, q[0].pc);
                checkVal("instr", bus.instr, q[0].ins);
                checkVal("op", 32'(bus.op), 32'(q[0].ins[6:0]));
            end
            checkVal("misalign", 32'(bus.misalign), 32'(halted));
            if (bus.imem_req) checkVal("reqWhileBusy", 32'({pendValid, q.size() > 1}), 32'd0);
            if (halted) checkVal("haltReq", 32'(bus.imem_req), 32'd0);
            if (justReset) begin
                checkVal("rstReq", 32'(bus.imem_req), 32'd0);
                checkVal("rstValid", 32'(bus.instr_valid), 32'd0);
                checkVal("rstInstr", bus.instr, 32'd0);
                checkVal("rstOp", 32'(bus.op), 32'd0);
                checkVal("rstPc", bus.instr_pc, 32'd0);
            end
            if (prevHold) begin
                checkVal("holdReq", 32'(bus.imem_req), 32'd1);
                checkVal("holdAddr", bus.imem_addr, prevAddr);
            end
            if (!halted && sinceProgress > 60) begin
                checkVal("stall", sinceProgress, 32'd0);
                sinceProgress = 0;
            end
        end

        rst             = doRst;
        bus.imem_gnt    = ($urandom_range(99) < gntPct);
        bus.instr_ready = ($urandom_range(99) < readyPct);
        rv = 1'b0;
        rd = $urandom;
        if (pendValid && !doRst) begin
            if (pendCnt == 0) begin
                rv = 1'b1;
                rd = memWord(pendAddr);
            end else pendCnt--;
        end
        if (forceStale) begin
            rv = 1'b1;
            forceStale = 0;
        end
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        if (forceRedir) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = forceRedirPc;
            forceRedir      = 0;
        end else begin
            bus.redirect    = ($urandom_range(99) < redirPct);
            bus.redirect_pc = randTarget();
        end

        granted   = bus.imem_req && bus.imem_gnt;
        pop       = (q.size() != 0) && bus.instr_ready;
        prevHold  = bus.imem_req && !bus.imem_gnt && !bus.redirect && !doRst;
        prevAddr  = bus.imem_addr;
        justReset = doRst;
        lastGrant = granted && !doRst;
        if (granted || pop || doRst) sinceProgress = 0;
        else sinceProgress++;

        if (doRst) begin
            q.delete();
            pendValid = 0;
            nextFetch = RST_PC;
            halted    = 0;
            epoch++;
        end else begin
            respOk = rv && pendValid && (pendEpoch == epoch) && !bus.redirect && !halted;
            if (rv) pendValid = 0;
            oldEpoch = epoch;
            if (!halted) begin
                if (granted) checkVal("gntAddr", bus.imem_addr, nextFetch);
                if (bus.redirect) begin
                    tgt = bus.redirect_pc;
                    q.delete();
                    epoch++;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (tgt[1:0] != 2'b00) halted = 1;
                    else nextFetch = tgt;
`else
                    nextFetch = {tgt[31:2], 2'b00};
`endif
                end else begin
                    if (pop) void'(q.pop_front());
                    if (respOk) q.push_back('{pc: pendAddr, ins: rd});
                    if (granted) nextFetch += 32'd4;
                end
                if (granted) begin
                    pendValid = 1;
                    pendAddr  = bus.imem_addr;
                    pendEpoch = oldEpoch;
                    pendCnt   = $urandom_range(delayMax, delayMin);
                end
            end
        end
    endtask

    initial begin
        int unsigned n;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
        bus.redirect = 0; bus.redirect_pc = '0; bus.instr_ready = 0;

        step(1); step(1);
        repeat (24) step(0);

        // backpressure
        readyPct = 0;
        repeat (6) step(0);
        checkVal("fullValid", 32'(bus.instr_valid), 32'd1);
        checkVal("fullNoReq", 32'(bus.imem_req), 32'd0);
        readyPct = 100;
        repeat (12) step(0);

        // redirect while waiting on a response
        delayMin = 2; delayMax = 2;
        n = 0;
        do begin step(0); n++; end while (!lastGrant && n < 20);
        checkVal("grantTimeout", 32'(lastGrant), 32'd1);
        forceRedir = 1; forceRedirPc = 32'h100;
        step(0);
        delayMin = 0; delayMax = 0;
        repeat (12) step(0);

        // grant stall
        gntPct = 0;
        repeat (6) step(0);
        checkVal("stallReq", 32'(bus.imem_req), 32'd1);
        gntPct = 100;
        repeat (8) step(0);

        // reset with data buffered and a request outstanding
        readyPct = 0; delayMin = 3; delayMax = 3;
        n = 0;
        do begin step(0); n++; end while (!(lastGrant && q.size() >= 1) && n < 30);
        checkVal("fillTimeout", 32'(lastGrant && q.size() >= 1), 32'd1);
        step(0);
        step(1);
        forceStale = 1;
        readyPct = 100; delayMin = 0; delayMax = 0;
        repeat (12) step(0);

        // address wrap past the top of memory
        forceRedir = 1; forceRedirPc = 32'hFFFF_FFF8;
        repeat (14) step(0);

        // misaligned redirect target
        forceRedir = 1; forceRedirPc = 32'h102;
        repeat (10) step(0);
        step(1);
        repeat (6) step(0);

        // randomized traffic
        gntPct = 60; readyPct = 70; redirPct = 3; delayMin = 0; delayMax = 3;
        repeat (3000) step(0);
        redirPct = 0;
        repeat (20) step(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
